// File: rtl/vga_plot_engine.sv
// vga_plot_engine: Avalon-MM pixel plotter with FIFO buffering and a
// hardware full-screen fill engine.
//
// Ports:
//   clk, reset         single clock, asynchronous active-high reset
//   address/read/...   Avalon-MM slave (readdata latency 1, waitrequest stall)
//   plot/x/y/colour    registered pixel stream to the framebuffer adapter
//
// Register map (word offsets): 0 PIXEL(W), 1 FILL(W), 2 STATUS(R), 3 DROPCLR(W).
// writedata fields: y=[Y_W-1:0], x=[8+:X_W], colour=[16+:COLOUR_W].
module vga_plot_engine #(
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 3,
  parameter int H_RES      = 160,
  parameter int V_RES      = 120,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          address,
  input  logic                read,
  output logic [31:0]         readdata,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic                waitrequest,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = X_W + Y_W + COLOUR_W;

  typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;

  state_t state, next_state;

  logic [X_W-1:0]      wx, fx;
  logic [Y_W-1:0]      wy, fy;
  logic [COLOUR_W-1:0] wc, fill_col;
  logic                on_screen, accept, push, pop, full, empty, busy;
  logic                fill_req, fill_last, drain_done;
  logic [15:0]         drop;
  logic [PW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       cnt;
  logic [31:0]         status;
  logic                unused_wdata;

  assign wy = writedata[0 +: Y_W];
  assign wx = writedata[8 +: X_W];
  assign wc = writedata[16 +: COLOUR_W];
  assign unused_wdata = ^writedata;

  assign on_screen = (32'(wx) < H_RES) && (32'(wy) < V_RES);
  assign full      = (cnt == CW'(FIFO_DEPTH));
  assign empty     = (cnt == '0);
  assign busy      = (state != IDLE) || !empty;

  // Off-screen pixels never stall; FILL stalls until the engine is back in IDLE.
  assign waitrequest = write && (((address == 4'd0) && on_screen && full) ||
                                 ((address == 4'd1) && (state != IDLE)));
  assign accept   = write && !waitrequest;
  assign push     = accept && (address == 4'd0) && on_screen;
  assign fill_req = accept && (address == 4'd1);
  // The fill sweep owns the output stream, so the FIFO only drains outside FILL.
  assign pop      = (state != FILL) && !empty;

  assign fill_last  = (fx == X_W'(H_RES - 1)) && (fy == Y_W'(V_RES - 1));
  assign drain_done = (state == DRAIN) && empty;

  assign status = {drop, 8'(cnt), 6'b0, full, busy};

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fill_req)  next_state = DRAIN;
      DRAIN:   if (empty)     next_state = FILL;
      FILL:    if (fill_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FIFO storage carries no reset; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wx, wy, wc};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Fill sweep position and colour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fx       <= '0;
      fy       <= '0;
      fill_col <= '0;
    end else begin
      if (fill_req) fill_col <= wc;
      if (drain_done) begin
        fx <= '0;
        fy <= '0;
      end else if (state == FILL) begin
        if (fx == X_W'(H_RES - 1)) begin
          fx <= '0;
          fy <= fy + Y_W'(1);
        end else begin
          fx <= fx + X_W'(1);
        end
      end
    end
  end

  // Registered pixel stream; coordinates hold when nothing is emitted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      plot <= 1'b0;
      if (pop) begin
        plot               <= 1'b1;
        {x, y, colour}     <= mem[rd_ptr];
      end else if (state == FILL) begin
        plot   <= 1'b1;
        x      <= fx;
        y      <= fy;
        colour <= fill_col;
      end
    end
  end

  // Drop counter: saturates; DROPCLR cannot coincide with a PIXEL write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop <= '0;
    end else if (accept && (address == 4'd3)) begin
      drop <= '0;
    end else if (accept && (address == 4'd0) && !on_screen && (drop != 16'hFFFF)) begin
      drop <= drop + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     readdata <= '0;
    else if (read) readdata <= (address == 4'd2) ? status : 32'd0;
  end

endmodule

// File: tb/tb_vga_plot_engine.sv
// Self-checking bench for vga_plot_engine (default parameters).
// A scoreboard queue receives every expected plot in program order when a
// write is accepted; a negedge monitor pops and compares each emitted plot.
module tb_vga_plot_engine;

  localparam int HR = 160;
  localparam int VR = 120;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        read, write;
  logic [31:0] readdata, writedata;
  logic        waitrequest, plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;

  int n_chk  = 0;
  int n_pass = 0;
  logic [23:0] sb[$];

  vga_plot_engine dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .readdata(readdata),
    .write(write), .writedata(writedata), .waitrequest(waitrequest),
    .plot(plot), .x(x), .y(y), .colour(colour)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [23:0] pk(input int px, input int py, input int pc);
    return {8'(px), 8'(py), 8'(pc)};
  endfunction

  function automatic logic [31:0] wd(input int px, input int py, input int pc);
    return (32'(pc) << 16) | (32'(px) << 8) | 32'(py);
  endfunction

  // Model of an accepted write: program-order expected plots.
  task automatic model_accept(input logic [3:0] a, input logic [31:0] d);
    int px, py, pc;
    px = int'(d[15:8]); py = int'(d[6:0]); pc = int'(d[18:16]);
    if (a == 4'd0 && px < HR && py < VR) sb.push_back(pk(px, py, pc));
    if (a == 4'd1)
      for (int fy = 0; fy < VR; fy++)
        for (int fx = 0; fx < HR; fx++) sb.push_back(pk(fx, fy, pc));
  endtask

  // All bus tasks start and end #1 after a rising edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output int stalls);
    address = a; writedata = d; write = 1'b1; stalls = 0;
    forever begin
      @(negedge clk);
      if (!waitrequest) break;
      stalls++;
      if (stalls > 40000) begin
        check("write_timeout", 64'(stalls), 0);
        @(posedge clk); #1 write = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    @(posedge clk);
    model_accept(a, d);
    #1 write = 1'b0;
  endtask

  task automatic hold_write(input logic [3:0] a, input logic [31:0] d, input int n);
    address = a; writedata = d; write = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("held_stall", waitrequest, 1);
      @(posedge clk); #1;
    end
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(posedge clk); #1 read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_empty(input int max);
    int c = 0;
    while (sb.size() != 0 && c < max) begin @(posedge clk); c++; end
    #1;
    check("drain_timeout", 64'(sb.size()), 0);
  endtask

  task automatic wait_size(input int lim, input int max);
    int c = 0;
    while (sb.size() > lim && c < max) begin @(posedge clk); c++; end
    #1;
    check("wait_size", 64'(sb.size() > lim), 0);
  endtask

  // Plot monitor.
  always @(negedge clk) begin
    if (!reset && plot) begin
      if (sb.size() == 0) check("unexpected_plot", pk(int'(x), int'(y), int'(colour)), 24'hFFFFFF);
      else check("pixel", pk(int'(x), int'(y), int'(colour)), sb.pop_front());
    end
  end

  initial begin
    logic [31:0] rd;
    int st;
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_plot", plot, 0);
    check("rst_xyc", {x, y, colour}, 0);
    check("rst_readdata", readdata, 0);
    check("rst_wait", waitrequest, 0);
    @(posedge clk); #1;
    bus_read(4'd2, rd);
    check("rst_status", rd, 0);

    // Single pixel: one-edge latency, exactly one plot cycle.
    bus_write(4'd0, 32'h0005_2A10, st);
    check("single_stall", 64'(st), 0);
    @(negedge clk); check("single_lat0", plot, 0);
    @(negedge clk); check("single_lat1", plot, 1);
    check("single_xyc", pk(int'(x), int'(y), int'(colour)), pk(42, 16, 5));
    @(negedge clk); check("single_once", plot, 0);
    @(posedge clk); #1;
    bus_read(4'd0, rd); check("rd_addr0", rd, 0);
    bus_read(4'd7, rd); check("rd_addr7", rd, 0);

    // Off-screen drops and DROPCLR.
    bus_write(4'd0, wd(160, 5, 1), st); check("off_x_stall", 64'(st), 0);
    bus_write(4'd0, wd(3, 120, 1), st); check("off_y_stall", 64'(st), 0);
    bus_read(4'd2, rd); check("drop_two", rd[31:16], 2);
    check("off_busy", rd[0], 0);
    bus_write(4'd3, 32'd0, st);
    bus_read(4'd2, rd); check("dropclr", rd[31:16], 0);

    // Saturation.
    for (int i = 0; i < 65535; i++) bus_write(4'd0, wd(200, 7, 0), st);
    bus_read(4'd2, rd); check("drop_max", rd[31:16], 16'hFFFF);
    bus_write(4'd0, wd(7, 127, 0), st);
    bus_read(4'd2, rd); check("drop_sat", rd[31:16], 16'hFFFF);
    bus_write(4'd3, 32'd0, st);

    // Fill with queued pixels first, then back-pressure during the fill.
    bus_write(4'd0, wd(1, 2, 3), st);
    bus_write(4'd0, wd(159, 119, 7), st);
    bus_write(4'd0, wd(0, 0, 6), st);
    bus_write(4'd1, wd(0, 0, 2), st);
    wait_size(HR * VR, 100);
    for (int i = 0; i < 16; i++) begin
      bus_write(4'd0, wd(i * 9, i * 7, i % 8), st);
      check("bp_accept", 64'(st), 0);
    end
    hold_write(4'd0, wd(150, 100, 4), 1);
    bus_read(4'd2, rd);
    check("bp_full", rd[1], 1);
    check("bp_count", rd[15:8], 16);
    check("bp_busy", rd[0], 1);
    bus_write(4'd0, wd(150, 100, 4), st);
    check("bp_stalled", 64'(st > 0), 1);
    wait_empty(25000);
    bus_read(4'd2, rd);
    check("fill_idle", rd[1:0], 0);

    // Fill from IDLE/empty: first plot two edges after the FILL write.
    bus_write(4'd1, wd(0, 0, 5), st);
    @(negedge clk); check("fill_lat0", plot, 0);
    @(negedge clk); check("fill_lat1", plot, 0);
    @(negedge clk); check("fill_lat2", plot, 1);
    @(posedge clk); #1;
    wait_size(HR * VR - 100, 500);
    hold_write(4'd1, wd(0, 0, 1), 100);
    wait_size(HR * VR - 500, 1000);

    // Reset mid-fill.
    #2 reset = 1'b1;
    #1 check("midrst_plot", plot, 0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    check("midrst_wait", waitrequest, 0);
    check("midrst_rdata", readdata, 0);
    bus_read(4'd2, rd); check("midrst_status", rd, 0);
    bus_write(4'd0, wd(77, 55, 3), st);
    @(negedge clk); check("post_rst_lat0", plot, 0);
    @(negedge clk); check("post_rst_plot", plot, 1);
    @(posedge clk); #1;
    wait_empty(10);
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
